// File: rtl/key_request_if.sv
// Pedestrian key bundle: raw key and sequencer ack in, debounced level, press events and
// the held pedestrian request out.
interface key_request_if;
    logic key_n;
    logic req_ack;
    logic key_level;
    logic short_pulse;
    logic long_pulse;
    logic ped_req;

    // Driver side: the button and the light sequencer
    modport master (
        output key_n,
        output req_ack,
        input  key_level,
        input  short_pulse,
        input  long_pulse,
        input  ped_req
    );

    // Controller side
    modport slave (
        input  key_n,
        input  req_ack,
        output key_level,
        output short_pulse,
        output long_pulse,
        output ped_req
    );
endinterface

// File: rtl/key_request_ctrl.sv
// Pedestrian push-button front end: synchronises and debounces the active-low key, classifies
// each press as short or long, and holds a pedestrian request until the sequencer acks it.
module key_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 640000,
    parameter int unsigned LONG_CYCLES     = 64000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    key_request_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StLongHeld
    } state_e;

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic [1:0]       r_sync;
    logic             w_key_sync;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_key_level;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_short;
    logic             w_short_nxt;
    logic             r_long;
    logic             w_long_nxt;
    logic             r_ped_req;

    assign w_key_sync = r_sync[1];

    // Two-flop synchroniser; resets to "released" so a held key must debounce again
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.key_n};
        end
    end

    // Debounce: accept a new level only after it differs from key_level for DEBOUNCE_CYCLES
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_db_cnt    <= '0;
            r_key_level <= 1'b1;
        end else if (w_key_sync == r_key_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DbLast) begin
            r_key_level <= w_key_sync;
            r_db_cnt    <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + CntOne;
        end
    end

    // Press classifier state, hold counter and registered event pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= StIdle;
            r_hold_cnt <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_short    <= w_short_nxt;
            r_long     <= w_long_nxt;
        end
    end

    // Next-state logic; a release seen in PRESS wins over reaching the long threshold
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        case (r_state)
            StIdle: begin
                if (!r_key_level) begin
                    w_state_nxt = StPress;
                    w_hold_nxt  = '0;
                end
            end
            StPress: begin
                if (r_key_level) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end else if (r_hold_cnt == HoldLast) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = StLongHeld;
                end else begin
                    w_hold_nxt = r_hold_cnt + CntOne;
                end
            end
            StLongHeld: begin
                // Counter frozen: one long pulse per press, however long it is held
                if (r_key_level) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Request latch: cancel beats set, and a fresh short press survives a same-cycle ack
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ped_req <= 1'b0;
        end else if (r_long) begin
            r_ped_req <= 1'b0;
        end else if (r_short) begin
            r_ped_req <= 1'b1;
        end else if (r_ped_req && bus.req_ack) begin
            r_ped_req <= 1'b0;
        end
    end

    assign bus.key_level   = r_key_level;
    assign bus.short_pulse = r_short;
    assign bus.long_pulse  = r_long;
    assign bus.ped_req     = r_ped_req;

endmodule

// File: tb/tb_key_request_ctrl.sv
// Directed bench for key_request_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_request_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_short  = 0;
    int n_long   = 0;
    int n_both   = 0;
    int n_kl_low = 0;

    key_request_if u_if ();

    key_request_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16),
        .CNT_W          (8)
    ) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (u_if)
    );

    always #5 sys_clk = ~sys_clk;

    // Event tallies sampled mid-cycle
    always @(negedge sys_clk) begin
        if (u_if.short_pulse === 1'b1) n_short++;
        if (u_if.long_pulse === 1'b1) n_long++;
        if (u_if.short_pulse === 1'b1 && u_if.long_pulse === 1'b1) n_both++;
        if (u_if.key_level === 1'b0) n_kl_low++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clr_counts();
        n_short  = 0;
        n_long   = 0;
        n_kl_low = 0;
    endtask

    initial begin
        u_if.key_n   = 1'b1;
        u_if.req_ack = 1'b0;

        // 1. Reset with a toggling key, then release with the key up
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            u_if.key_n = ~u_if.key_n;
        end
        cyc(1);
        chk("rst_key_level", u_if.key_level, 1);
        chk("rst_short", u_if.short_pulse, 0);
        chk("rst_long", u_if.long_pulse, 0);
        chk("rst_ped_req", u_if.ped_req, 0);
        u_if.key_n = 1'b1;
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(10);
        chk("idle_key_level", u_if.key_level, 1);
        chk("idle_short", u_if.short_pulse, 0);
        chk("idle_long", u_if.long_pulse, 0);
        chk("idle_ped_req", u_if.ped_req, 0);

        // 2. Clean short press, 10 cycles low; key_level falls on edge 6, short at edge 17
        clr_counts();
        u_if.key_n = 1'b0;
        cyc(5);
        chk("t2_kl_edge5", u_if.key_level, 1);
        cyc(1);
        chk("t2_kl_edge6", u_if.key_level, 0);
        cyc(4);
        u_if.key_n = 1'b1;
        cyc(6);
        chk("t2_kl_rise", u_if.key_level, 1);
        chk("t2_short_early", u_if.short_pulse, 0);
        cyc(1);
        chk("t2_short", u_if.short_pulse, 1);
        chk("t2_ped_before", u_if.ped_req, 0);
        cyc(1);
        chk("t2_short_end", u_if.short_pulse, 0);
        chk("t2_ped_set", u_if.ped_req, 1);
        cyc(5);
        chk("t2_ped_hold", u_if.ped_req, 1);
        chk("t2_n_short", n_short, 1);
        chk("t2_n_long", n_long, 0);
        u_if.req_ack = 1'b1;
        cyc(1);
        chk("t2_ped_acked", u_if.ped_req, 0);
        u_if.req_ack = 1'b0;
        cyc(3);
        chk("t2_ped_stays0", u_if.ped_req, 0);
        // Ack with nothing pending is ignored
        u_if.req_ack = 1'b1;
        cyc(3);
        chk("t2_stray_ack", u_if.ped_req, 0);
        u_if.req_ack = 1'b0;

        // 3. Bounce: low 3, high 1, low 3, high -- never reaches the debounce limit
        clr_counts();
        u_if.key_n = 1'b0;
        cyc(3);
        u_if.key_n = 1'b1;
        cyc(1);
        u_if.key_n = 1'b0;
        cyc(3);
        u_if.key_n = 1'b1;
        cyc(10);
        chk("t3_kl_low_cycles", n_kl_low, 0);
        chk("t3_n_short", n_short, 0);
        chk("t3_n_long", n_long, 0);
        chk("t3_ped_req", u_if.ped_req, 0);

        // 4. Long press cancels a pending request
        u_if.key_n = 1'b0;
        cyc(10);
        u_if.key_n = 1'b1;
        cyc(12);
        chk("t4_ped_pre", u_if.ped_req, 1);
        clr_counts();
        u_if.key_n = 1'b0;
        cyc(22);
        chk("t4_long_early", u_if.long_pulse, 0);
        chk("t4_ped_early", u_if.ped_req, 1);
        cyc(1);
        chk("t4_long", u_if.long_pulse, 1);
        chk("t4_short_quiet", u_if.short_pulse, 0);
        chk("t4_ped_at_long", u_if.ped_req, 1);
        cyc(1);
        chk("t4_long_end", u_if.long_pulse, 0);
        chk("t4_ped_cancel", u_if.ped_req, 0);
        cyc(16);
        u_if.key_n = 1'b1;
        cyc(12);
        chk("t4_n_long", n_long, 1);
        chk("t4_n_short", n_short, 0);
        chk("t4_kl_released", u_if.key_level, 1);
        chk("t4_ped_after", u_if.ped_req, 0);

        // 5. New request and ack in the same cycle: the request survives
        u_if.key_n = 1'b0;
        cyc(10);
        u_if.key_n = 1'b1;
        cyc(12);
        chk("t5_ped_first", u_if.ped_req, 1);
        u_if.key_n = 1'b0;
        cyc(10);
        u_if.key_n = 1'b1;
        cyc(6);
        chk("t5_short_early", u_if.short_pulse, 0);
        cyc(1);
        chk("t5_short", u_if.short_pulse, 1);
        chk("t5_ped_merge", u_if.ped_req, 1);
        u_if.req_ack = 1'b1;
        cyc(1);
        chk("t5_ped_survives", u_if.ped_req, 1);
        u_if.req_ack = 1'b0;
        cyc(2);
        chk("t5_ped_hold", u_if.ped_req, 1);
        u_if.req_ack = 1'b1;
        cyc(1);
        chk("t5_ped_acked", u_if.ped_req, 0);
        u_if.req_ack = 1'b0;

        // 6. Reset during PRESS at hold_cnt=8 with the key still held
        cyc(3);
        clr_counts();
        u_if.key_n = 1'b0;
        cyc(15);
        chk("t6_long_pre", u_if.long_pulse, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_kl", u_if.key_level, 1);
        chk("t6_rst_short", u_if.short_pulse, 0);
        chk("t6_rst_long", u_if.long_pulse, 0);
        cyc(3);
        chk("t6_rst_n_short", n_short, 0);
        chk("t6_rst_n_long", n_long, 0);
        sys_rst_n = 1'b1;
        cyc(5);
        chk("t6_kl_edge5", u_if.key_level, 1);
        cyc(1);
        chk("t6_kl_edge6", u_if.key_level, 0);
        cyc(4);
        u_if.key_n = 1'b1;
        cyc(6);
        chk("t6_short_early", u_if.short_pulse, 0);
        chk("t6_n_short_early", n_short, 0);
        cyc(1);
        chk("t6_short", u_if.short_pulse, 1);
        chk("t6_long_quiet", u_if.long_pulse, 0);
        cyc(1);
        chk("t6_ped_set", u_if.ped_req, 1);
        cyc(5);
        chk("t6_n_short", n_short, 1);
        chk("t6_n_long", n_long, 0);

        chk("never_both_pulses", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
